// File: rtl/accumulator_memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// accumulator_memory_arbiter_if
//
// Processor-side bus of the accumulator shared memory. One lane per
// processor, packed side by side in each vector.
//   req    : per-processor bus request            (processor -> memory)
//   grant  : one-hot bus grant, registered         (memory -> processor)
//   op     : 2 bits per processor, [2i+1:2i]       (processor -> memory)
//            00 NOP, 01 FETCH, 10 SEND, 11 NOP
//   signal : one-cycle op strobe per processor     (processor -> memory)
//   write  : 32-bit SEND word per processor        (processor -> memory)
//   read   : broadcast FETCH data                   (memory -> processor)
// Modports: master = processor side, slave = memory/arbiter side.
// ---------------------------------------------------------------------------
interface accumulator_memory_arbiter_if #(
  parameter int NUM_PROC = 4
);
  logic [NUM_PROC-1:0]    req;
  logic [NUM_PROC-1:0]    grant;
  logic [2*NUM_PROC-1:0]  op;
  logic [NUM_PROC-1:0]    signal;
  logic [32*NUM_PROC-1:0] write;
  logic [31:0]            read;

  modport master (
    output req, op, signal, write,
    input  grant, read
  );

  modport slave (
    input  req, op, signal, write,
    output grant, read
  );
endinterface

// File: rtl/accumulator_memory_arbiter.sv
// ---------------------------------------------------------------------------
// accumulator_memory_arbiter
//
// Shared-memory responder for the accumulator processor bus. Owns a LIFO
// operand stack that is preloaded through the load port; processors take
// turns (round-robin) to FETCH operands and SEND back sums until a single
// result remains on the stack.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous reset, active low (0 = reset)
//   bus        : processor bus (slave modport): req/grant/op/signal/write/read
//   load_en    : preload push strobe, accepted only while load_ready
//   load_data  : preload value
//   load_ready : high when the arbiter is idle with no grant active
//   count      : current stack occupancy (0..DEPTH)
//   done       : count==1, no outstanding fetches and no requests
//   result     : stack top (0 when empty), valid while done
//   err        : sticky; fetch on empty or push on full
//
// Optional build macro ACCUM_MEM_STATS_EN adds:
//   fetch_cnt  : saturating count of successful FETCHes
//   send_cnt   : saturating count of successful SENDs
// ---------------------------------------------------------------------------
module accumulator_memory_arbiter #(
  parameter int NUM_PROC = 4,
  parameter int DEPTH    = 16,
  parameter int AW       = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  accumulator_memory_arbiter_if.slave bus,
  input  logic                        load_en,
  input  logic [31:0]                 load_data,
  output logic                        load_ready,
  output logic [AW:0]                 count,
  output logic                        done,
  output logic [31:0]                 result,
  output logic                        err
`ifdef ACCUM_MEM_STATS_EN
  ,
  output logic [15:0]                 fetch_cnt,
  output logic [15:0]                 send_cnt
`endif
);

  localparam int PW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  // Outstanding-fetch tracker width; it saturates rather than wraps.
  localparam int OW = 8;

  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [OW-1:0] OUT_ONE   = 1;
  localparam logic [OW-1:0] OUT_TWO   = 2;
  localparam logic [OW-1:0] OUT_MAX   = '1;
  localparam logic [1:0]    OP_FETCH  = 2'b01;
  localparam logic [1:0]    OP_SEND   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_PROC-1:0] grant_q, grant_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [31:0]         read_q, read_d;
  logic [AW:0]         count_q, count_d;
  logic [OW-1:0]       outst_q, outst_d;
  logic                err_q, err_d;

  logic [31:0]         stack_q [DEPTH];
  logic                push_en;
  logic [31:0]         push_data;

  logic [AW-1:0]       top_idx;
  logic [31:0]         top_word;
  logic                empty;
  logic                full;

  logic [1:0]          own_op;
  logic                own_sig;
  logic                own_req;
  logic [31:0]         own_wdata;

  logic                win_found;
  logic [PW-1:0]       win_idx;

  // count==DEPTH leaves the low AW bits at 0, so subtracting one still
  // lands on the last entry.
  assign top_idx  = count_q[AW-1:0] - AW'(1);
  assign top_word = stack_q[top_idx];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);

  // While owning, ptr_q is the granted processor; only its lane is looked at.
  assign own_op    = bus.op[2*int'(ptr_q) +: 2];
  assign own_sig   = bus.signal[ptr_q];
  assign own_req   = bus.req[ptr_q];
  assign own_wdata = bus.write[32*int'(ptr_q) +: 32];

  // Round-robin search: first requester strictly after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int i = 1; i <= NUM_PROC; i++) begin
      if (!win_found && bus.req[(int'(ptr_q) + i) % NUM_PROC]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(ptr_q) + i) % NUM_PROC);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    read_d    = read_q;
    count_d   = count_q;
    outst_d   = outst_q;
    err_d     = err_q;
    push_en   = 1'b0;
    push_data = '0;

    unique case (state_q)
      S_IDLE: begin
        // A load and an arbitration win may land in the same cycle.
        if (load_en && load_ready) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            push_en   = 1'b1;
            push_data = load_data;
            count_d   = count_q + CNT_ONE;
          end
        end
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          ptr_d            = win_idx;
          state_d          = S_OWN;
        end
      end

      S_OWN: begin
        if (own_sig) begin
          if (own_op == OP_FETCH) begin
            if (empty) begin
              read_d = '0;
              err_d  = 1'b1;
            end else begin
              read_d  = top_word;
              count_d = count_q - CNT_ONE;
              if (outst_q != OUT_MAX) begin
                outst_d = outst_q + OUT_ONE;
              end
            end
          end else if (own_op == OP_SEND) begin
            if (full) begin
              err_d = 1'b1;
            end else begin
              push_en   = 1'b1;
              push_data = own_wdata;
              count_d   = count_q + CNT_ONE;
              outst_d   = (outst_q > OUT_ONE) ? (outst_q - OUT_TWO) : '0;
            end
          end
        end
        // An op strobed in the release cycle has already been handled above.
        if (!own_req) begin
          grant_d = '0;
          state_d = S_RELEASE;
        end
      end

      S_RELEASE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(NUM_PROC - 1);
      read_q  <= '0;
      count_q <= '0;
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      read_q  <= read_d;
      count_q <= count_d;
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  // Stack storage has no reset; occupancy alone defines its contents.
  always_ff @(posedge clk) begin
    if (reset && push_en) begin
      stack_q[count_q[AW-1:0]] <= push_data;
    end
  end

`ifdef ACCUM_MEM_STATS_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] send_cnt_q, send_cnt_d;
  logic        fetch_ok;
  logic        send_ok;

  always_comb begin
    fetch_ok    = (state_q == S_OWN) && own_sig && (own_op == OP_FETCH) && !empty;
    send_ok     = (state_q == S_OWN) && own_sig && (own_op == OP_SEND) && !full;
    fetch_cnt_d = fetch_cnt_q;
    send_cnt_d  = send_cnt_q;
    if (fetch_ok && (fetch_cnt_q != 16'hFFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    end
    if (send_ok && (send_cnt_q != 16'hFFFF)) begin
      send_cnt_d = send_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      send_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      send_cnt_q  <= send_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign send_cnt  = send_cnt_q;
`endif

  assign bus.grant  = grant_q;
  assign bus.read   = read_q;
  assign load_ready = (state_q == S_IDLE) && (grant_q == '0);
  assign count      = count_q;
  assign err        = err_q;
  assign result     = empty ? 32'd0 : top_word;
  assign done       = (count_q == CNT_ONE) && (outst_q == '0) && (bus.req == '0);

endmodule

// File: tb/tb_accumulator_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_accumulator_memory_arbiter
//
// Drives the processor bus and load port; keeps a queue-based model of the
// operand stack, the sticky error and the round-robin order. Expected FETCH
// data and expected grants go into queues; a negedge monitor pops and
// compares them when the DUT presents them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_accumulator_memory_arbiter;

  localparam int NUM_PROC = 4;
  localparam int DEPTH    = 16;
  localparam int AW       = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load_en = 1'b0;
  logic [31:0]       load_data = '0;
  logic              load_ready;
  logic [AW:0]       count;
  logic              done;
  logic [31:0]       result;
  logic              err;
`ifdef ACCUM_MEM_STATS_EN
  logic [15:0]       fetch_cnt;
  logic [15:0]       send_cnt;
`endif

  accumulator_memory_arbiter_if #(.NUM_PROC(NUM_PROC)) bus ();

  accumulator_memory_arbiter #(
    .NUM_PROC(NUM_PROC),
    .DEPTH(DEPTH),
    .AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .load_en(load_en),
    .load_data(load_data),
    .load_ready(load_ready),
    .count(count),
    .done(done),
    .result(result),
    .err(err)
`ifdef ACCUM_MEM_STATS_EN
    ,
    .fetch_cnt(fetch_cnt),
    .send_cnt(send_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [31:0]         m_stack[$];
  bit                  m_err;
  int                  m_outst;
  int                  m_ptr;

  // Scoreboard queues
  logic [31:0]         exp_read[$];
  logic [NUM_PROC-1:0] exp_grant[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [NUM_PROC-1:0] r);
    for (int i = 1; i <= NUM_PROC; i++) begin
      if (r[(m_ptr + i) % NUM_PROC]) return (m_ptr + i) % NUM_PROC;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_stack.delete();
    m_err   = 1'b0;
    m_outst = 0;
    m_ptr   = NUM_PROC - 1;
  endfunction

  function automatic void model_push(input logic [31:0] v);
    if (m_stack.size() < DEPTH) m_stack.push_back(v);
    else m_err = 1'b1;
  endfunction

  task automatic check_status(input string tag);
    logic [31:0] exp_top;
    exp_top = (m_stack.size() > 0) ? m_stack[$] : 32'd0;
    checkOutput({tag, " count"}, 32'(count), 32'(m_stack.size()));
    checkOutput({tag, " result"}, result, exp_top);
    checkOutput({tag, " err"}, 32'(err), 32'(m_err));
    checkOutput({tag, " done"}, 32'(done),
                32'(m_stack.size() == 1 && m_outst == 0 && bus.req == '0));
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    bus.req    = '0;
    bus.signal = '0;
    bus.op     = '0;
    load_en    = 1'b0;
    tick();
    tick();
    model_reset();
    reset = 1'b1;
  endtask

  // Caller guarantees the arbiter is idle, so the load is accepted.
  task automatic load_word(input logic [31:0] v);
    load_en   = 1'b1;
    load_data = v;
    model_push(v);
    tick();
    load_en = 1'b0;
  endtask

  task automatic arbitrate(input logic [NUM_PROC-1:0] r, input bit with_load,
                           input logic [31:0] ld, output int winner);
    logic [NUM_PROC-1:0] g;
    bit got;
    winner = model_pick(r);
    g = '0;
    g[winner] = 1'b1;
    exp_grant.push_back(g);
    m_ptr = winner;
    bus.req = r;
    if (with_load) begin
      load_en   = 1'b1;
      load_data = ld;
      model_push(ld);
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      load_en = 1'b0;
      if (bus.grant != '0) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant timeout: got %b expected %b", bus.grant, g);
    end
  endtask

  task automatic applyStimulus(input int p, input logic [1:0] code,
                               input logic [31:0] data, input bit rel, input bit noise);
    bus.op     = '0;
    bus.signal = '0;
    bus.op[2*p +: 2]     = code;
    bus.signal[p]        = 1'b1;
    bus.write[32*p +: 32] = data;
    if (noise) begin
      for (int q = 0; q < NUM_PROC; q++) begin
        if (q != p && $urandom_range(0, 1) == 1) begin
          bus.op[2*q +: 2]      = 2'($urandom_range(1, 2));
          bus.signal[q]         = 1'b1;
          bus.write[32*q +: 32] = $urandom();
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        load_en   = 1'b1;
        load_data = $urandom();
      end
    end
    if (rel) bus.req[p] = 1'b0;
    case (code)
      2'b01: begin
        if (m_stack.size() > 0) begin
          exp_read.push_back(m_stack.pop_back());
          m_outst++;
        end else begin
          exp_read.push_back(32'd0);
          m_err = 1'b1;
        end
      end
      2'b10: begin
        if (m_stack.size() < DEPTH) begin
          m_stack.push_back(data);
          m_outst = (m_outst >= 2) ? m_outst - 2 : 0;
        end else begin
          m_err = 1'b1;
        end
      end
      default: ;
    endcase
    tick();
    bus.signal = '0;
    bus.op     = '0;
    load_en    = 1'b0;
    if (rel) tick();
  endtask

  task automatic release_owner(input int p);
    bus.req[p] = 1'b0;
    tick();
    tick();
  endtask

  // Monitor: read is due one cycle after a granted FETCH strobe; grants are
  // compared each time the bus goes from no owner to an owner.
  logic [NUM_PROC-1:0] prev_grant = '0;
  int  gap = 0;
  bit  pend = 1'b0;
  bit  seen_grant = 1'b0;

  always @(negedge clk) begin
    if (pend) begin
      if (exp_read.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL read unexpected: got 0x%08h expected none", bus.read);
      end else begin
        checkOutput("read", bus.read, exp_read.pop_front());
      end
    end
    pend = 1'b0;
    if (reset) begin
      for (int q = 0; q < NUM_PROC; q++) begin
        if (bus.grant[q] && bus.signal[q] && bus.op[2*q +: 2] == 2'b01) pend = 1'b1;
      end
    end
    if (bus.grant != '0 && prev_grant == '0) begin
      if (exp_grant.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL grant unexpected: got %b expected none", bus.grant);
      end else begin
        checkOutput("grant", 32'(bus.grant), 32'(exp_grant.pop_front()));
      end
      if (seen_grant) checkOutput("grant gap", 32'(gap >= 2), 32'd1);
      seen_grant = 1'b1;
      gap = 0;
    end else if (bus.grant == '0) begin
      gap++;
    end
    prev_grant = bus.grant;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;
    logic [31:0] v;
    bus.req    = '0;
    bus.op     = '0;
    bus.signal = '0;
    bus.write  = '0;
    model_reset();

    // Reset state and simple preload
    do_reset();
    checkOutput("reset grant", 32'(bus.grant), 32'd0);
    checkOutput("reset read", bus.read, 32'd0);
    checkOutput("reset count", 32'(count), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset load_ready", 32'(load_ready), 32'd1);
    load_word(32'd3);
    load_word(32'd5);
    load_word(32'd7);
    check_status("preload");

    // Fetch, fetch, send the sum, release
    do_reset();
    load_word(32'd10);
    load_word(32'd20);
    arbitrate(4'b0001, 1'b0, 32'd0, w);
    checkOutput("owned load_ready", 32'(load_ready), 32'd0);
    applyStimulus(w, 2'b01, 32'd0, 1'b0, 1'b0);
    applyStimulus(w, 2'b01, 32'd0, 1'b0, 1'b0);
    applyStimulus(w, 2'b10, 32'd30, 1'b0, 1'b0);
    release_owner(w);
    check_status("sum");

    // Round-robin with all processors requesting
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      arbitrate(4'b1111, 1'b0, 32'd0, w);
      applyStimulus(w, 2'b00, 32'd0, 1'b0, 1'b1);
      bus.req[w] = 1'b0;
      tick();
      if (k < 4) bus.req[w] = 1'b1;
      tick();
    end
    bus.req = '0;
    tick();
    tick();

    // Fetch on empty stack; sticky error
    do_reset();
    load_word(32'd42);
    arbitrate(4'b0100, 1'b0, 32'd0, w);
    applyStimulus(w, 2'b01, 32'd0, 1'b0, 1'b0);
    applyStimulus(w, 2'b01, 32'd0, 1'b0, 1'b0);
    release_owner(w);
    check_status("empty fetch");
    load_word(32'd9);
    tick();
    check_status("err sticky");
    do_reset();
    check_status("err cleared");

    // Overflow through the load port
    do_reset();
    for (int i = 0; i < DEPTH; i++) load_word($urandom());
    check_status("full");
    load_word(32'hDEAD_BEEF);
    check_status("overflow");

    // Reset in the middle of an ownership
    do_reset();
    load_word(32'd11);
    load_word(32'd12);
    arbitrate(4'b0100, 1'b0, 32'd0, w);
    applyStimulus(w, 2'b01, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    checkOutput("midreset grant", 32'(bus.grant), 32'd0);
    checkOutput("midreset count", 32'(count), 32'd0);
    checkOutput("midreset read", bus.read, 32'd0);
    model_reset();
    bus.req = '0;
    reset   = 1'b1;
    tick();
    arbitrate(4'b0101, 1'b0, 32'd0, w);
    release_owner(w);

    // Randomised ownerships with noise on the other lanes
    do_reset();
    for (int i = 0; i < 4; i++) load_word($urandom_range(0, 1000));
    for (int it = 0; it < 40; it++) begin
      int p;
      int n;
      bit combined;
      logic [NUM_PROC-1:0] r;
      p = $urandom_range(0, NUM_PROC - 1);
      r = '0;
      r[p] = 1'b1;
      v = $urandom_range(0, 1000);
      arbitrate(r, ($urandom_range(0, 2) == 0), v, w);
      n = $urandom_range(1, 4);
      combined = ($urandom_range(0, 1) == 1);
      for (int j = 0; j < n; j++) begin
        applyStimulus(w, 2'($urandom_range(0, 3)), $urandom_range(0, 5000),
                      combined && (j == n - 1), 1'b1);
      end
      if (!combined) release_owner(w);
      check_status("random");
      if ($urandom_range(0, 3) == 0) load_word($urandom_range(0, 1000));
    end

    tick();
    tick();
    checkOutput("read queue drained", 32'(exp_read.size()), 32'd0);
    checkOutput("grant queue drained", 32'(exp_grant.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accumulator_memory_arbiter.md
Name: accumulator_memory_arbiter

Overview:
- Shared-memory responder and arbiter on the far end of the accumulator processor bus: owns the operand store and answers each processor's req/grant, op, signal, write and read handshake.
- Operand store is a LIFO stack. It is preloaded with N numbers; processors repeatedly FETCH two operands and SEND back one sum until a single result remains.
- Round-robin arbitration gives exactly one processor bus ownership at a time.

Parameters:
- NUM_PROC, 4, number of attached processors.
- DEPTH, 16, stack entries (power of 2).
- AW, 4, log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- req  in  NUM_PROC  per-processor bus request.
- grant  out  NUM_PROC  one-hot bus grant, registered.
- op  in  2*NUM_PROC  per-processor op; bits [2i+1:2i] = proc i. 00 NOP, 01 FETCH, 10 SEND, 11 treated as NOP.
- signal  in  NUM_PROC  per-processor op strobe, one cycle.
- write  in  32*NUM_PROC  per-processor SEND data; bits [32i+31:32i].
- read  out  32  broadcast FETCH data.
- load_en  in  1  preload push strobe.
- load_data  in  32  preload value.
- load_ready  out  1  high when no grant is active.
- count  out  AW+1  current stack occupancy.
- done  out  1  high when count==1, outstanding==0 and req==0.
- result  out  32  stack top; valid while done.
- err  out  1  sticky: fetch on empty or push on full.

Behaviour:
- Reset (reset==0 at posedge):
  - grant=0, read=0, count=0, err=0, outstanding=0.
  - Round-robin pointer = NUM_PROC-1, so proc 0 wins first; FSM = IDLE.
  - Stack contents are don't-care.
- FSM states: IDLE, OWN, RELEASE.
- IDLE:
  - If req != 0, choose the first set bit searching upward from pointer+1 with wrap.
  - Register grant one-hot and update pointer to the winner; go to OWN.
  - Grant is visible the cycle after req is sampled.
- OWN:
  - Only the granted processor's op, signal and write are sampled; all other inputs are ignored.
  - signal=1 and op=FETCH:
    - Non-empty: pop; read <= top at the next edge (1-cycle latency); outstanding += 1.
    - Empty: read <= 0, err <= 1, count unchanged.
  - signal=1 and op=SEND:
    - Not full: push write word; outstanding -= 2, saturating at 0.
    - Full: word dropped, err <= 1.
  - NOP, or signal=0: no action; read holds its value.
  - Granted req observed low: grant <= 0 and go to RELEASE. An op strobed in that same cycle is still executed.
- RELEASE: one dead cycle, then IDLE. Minimum 2 cycles between grants to different processors.
- Load port:
  - load_en is accepted only when load_ready (FSM in IDLE and grant==0). Accepted load pushes load_data.
  - Load on full sets err. load_en while not ready is ignored.
  - A load and an arbitration win in the same IDLE cycle: the load is performed and grant still registers.
- count is exact at all times; it never exceeds DEPTH and never wraps below 0.
- done and result are combinational from registered state. result = stack[count-1] when count>0, else 0.
- Reset mid-transaction: grant drops on the next edge, read clears, and stack occupancy is discarded.

Optional Feature:
- Macro ACCUM_MEM_STATS_EN.
- When defined, two extra outputs are added:
  - fetch_cnt (16-bit): successful FETCHes.
  - send_cnt (16-bit): successful SENDs.
  - Both clear on reset and saturate at 16'hFFFF.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Preload 3,5,7 via load_en; no req -> count=3, result=7, done=0, err=0.
- Preload 10,20. Proc 0 FETCH, FETCH, SEND 30, then drops req -> read=20, then read=10, each 1 cycle after its strobe. Final count=1, result=30, done=1.
- req=4'b1111 held, each owner releases after one NOP -> grant sequence 0001, 0010, 0100, 1000, 0001, with one RELEASE cycle between grants.
- FETCH on empty stack -> read=0, err=1, count stays 0. err stays 1 until reset.
- Preload 16 words (DEPTH=16), then a 17th load_en -> count=16, err=1, top unchanged.
- Proc 2 granted, reset asserted low mid-OWN -> next edge: grant=0, count=0, read=0. Proc 0 wins the first arbitration after reset deasserts.
